// File: rtl/mem_lsu.sv
// Load/store unit between the execute stage and the single-port data memory.
// Optional feature: define MEM_LSU_RANGE_CHECK_EN to reject addresses beyond the memory size.
module mem_lsu #(
    parameter int DMEM_AW = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    output logic [31:0]        resp_rdata,
    output logic               resp_err,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic               dmem_we,
    output logic [31:0]        dmem_din,
    input  logic [31:0]        dmem_dout
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // RD    | memory read issued for load or sub-word store
    // LOAD  | read data valid, extract and register result
    // STORE | memory write (full word or merged sub-word)
    // RESP  | one-cycle response pulse
    typedef enum logic [2:0] {IDLE, RD, LOAD, STORE, RESP} state_t;

    state_t             state, state_nxt;
    logic [DMEM_AW+1:0] addr_q;
    logic [2:0]         f3_q;
    logic               we_q;
    logic [31:0]        wdata_q;

    logic        accept;
    logic        illegal, misalign, range_err, req_err, req_sw;
    logic [31:0] lane_word, load_data, store_data;

`ifdef MEM_LSU_RANGE_CHECK_EN
    assign range_err = |req_addr[31:DMEM_AW+2];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:DMEM_AW+2];
    assign range_err      = 1'b0;
`endif

    assign req_ready  = (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign req_sw     = req_we && (req_funct3 == 3'b010);
    assign resp_valid = (state == RESP);
    assign dmem_we    = (state == STORE);
    assign dmem_addr  = addr_q[DMEM_AW+1:2];
    assign dmem_din   = (state == STORE) ? store_data : 32'h0;

    always_comb begin
        illegal = 1'b1;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = req_we;
            default:                illegal = 1'b1;
        endcase
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_err  = illegal || misalign || range_err;
    end

    always_comb begin
        lane_word = dmem_dout >> {addr_q[1:0], 3'b000};
        load_data = 32'h0;
        case (f3_q)
            3'b000:  load_data = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b001:  load_data = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b010:  load_data = dmem_dout;
            3'b100:  load_data = {24'h0, lane_word[7:0]};
            3'b101:  load_data = {16'h0, lane_word[15:0]};
            default: load_data = 32'h0;
        endcase
    end

    // Sub-word stores overwrite only their lane of the word read in RD.
    always_comb begin
        store_data = dmem_dout;
        case (f3_q[1:0])
            2'b00:   store_data[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            2'b01:   store_data[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: store_data = wdata_q;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)     state_nxt = RESP;
                    else if (req_sw) state_nxt = STORE;
                    else             state_nxt = RD;
                end
            end
            RD:      state_nxt = we_q ? STORE : LOAD;
            LOAD:    state_nxt = RESP;
            STORE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            f3_q       <= 3'b000;
            we_q       <= 1'b0;
            wdata_q    <= 32'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            addr_q     <= req_addr[DMEM_AW+1:0];
            f3_q       <= req_funct3;
            we_q       <= req_we;
            wdata_q    <= req_wdata;
            resp_rdata <= 32'h0;
            resp_err   <= req_err;
        end else if (state == LOAD) begin
            resp_rdata <= load_data;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: behavioural data memory plus a word-array reference model,
// directed scenarios followed by random loads/stores.
module tb_mem_lsu;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'b000;
    logic [31:0]   req_addr = 32'h0;
    logic [31:0]   req_wdata = 32'h0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] dmem_addr;
    logic          dmem_we;
    logic [31:0]   dmem_din;
    logic [31:0]   dmem_dout;

    int checks = 0;
    int errors = 0;

    // Memory with registered read and read-before-write; backdoor port for preloading.
    logic [31:0]   mem [4096];
    int            wr_count [4096];
    int            total_wr = 0;
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [31:0]   bd_data = 32'h0;

    logic [31:0]   ref_mem [4096];

    mem_lsu #(.DMEM_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_din(dmem_din), .dmem_dout(dmem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (dmem_we) begin
            mem[dmem_addr]      <= dmem_din;
            wr_count[dmem_addr] <= wr_count[dmem_addr] + 1;
            total_wr            <= total_wr + 1;
        end
        dmem_dout <= mem[dmem_addr];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] data);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = idx[AW-1:0]; bd_data = data;
        @(posedge clk); #1;
        bd_we = 1'b0;
        ref_mem[idx] = data;
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_err(input bit we, input int f3, input logic [31:0] addr);
        bit ill;
        if (we) ill = (f3 > 2);
        else    ill = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        if (ill) return 1;
        if ((f3 % 4) == 1 && (addr % 2) != 0) return 1;
        if ((f3 % 4) == 2 && (addr % 4) != 0) return 1;
`ifdef MEM_LSU_RANGE_CHECK_EN
        if (addr >= 32'h4000) return 1;
`endif
        return 0;
    endfunction

    function automatic int word_idx(input logic [31:0] addr);
        return int'((addr / 4) % 4096);
    endfunction

    function automatic logic [31:0] model_load(input int f3, input logic [31:0] addr);
        longint w, v;
        int     off;
        w   = longint'(ref_mem[word_idx(addr)]);
        off = int'(addr % 4);
        case (f3)
            0: begin v = (w >> (8 * off)) % 256;   if (v >= 128)   v -= 256;   end
            1: begin v = (w >> (8 * off)) % 65536; if (v >= 32768) v -= 65536; end
            2: v = w;
            4: v = (w >> (8 * off)) % 256;
            5: v = (w >> (8 * off)) % 65536;
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    task automatic model_store(input int f3, input logic [31:0] addr, input logic [31:0] wd);
        longint w, mask, data;
        int     sh;
        w  = longint'(ref_mem[word_idx(addr)]);
        sh = 8 * int'(addr % 4);
        case (f3)
            0: begin mask = 64'hFF << sh;   data = (longint'(wd) % 256) << sh;   end
            1: begin mask = 64'hFFFF << sh; data = (longint'(wd) % 65536) << sh; end
            default: begin mask = 64'hFFFF_FFFF; data = longint'(wd); end
        endcase
        w = (w & ~mask) | data;
        ref_mem[word_idx(addr)] = w[31:0];
    endtask

    // One transaction; while busy, a bogus SW request is held on the bus and must be ignored.
    task automatic do_req(input bit we, input int f3, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3[2:0]; req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_0FFC; req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        rd  = resp_rdata;
        err = resp_err;
        req_valid = 1'b0;
        if (!resp_valid) lat = 99;
        @(posedge clk); #1;
        check("resp_pulse_width", {31'h0, resp_valid}, 32'h0);
    endtask

    task automatic run_op(input string tag, input bit we, input int f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd);
        bit          e_err;
        logic [31:0] e_rd;
        int          e_lat, lat, wr_before;
        logic        err;
        e_err = model_err(we, f3, addr);
        e_rd  = (!e_err && !we) ? model_load(f3, addr) : 32'h0;
        if (e_err)                e_lat = 1;
        else if (we && f3 == 2)   e_lat = 2;
        else                      e_lat = 3;
        wr_before = total_wr;
        do_req(we, f3, addr, wd, rd, err, lat);
        check({tag, "_err"}, {31'h0, err}, {31'h0, e_err});
        check({tag, "_rdata"}, rd, e_rd);
        check({tag, "_latency"}, lat, e_lat);
        check({tag, "_writes"}, total_wr - wr_before, (we && !e_err) ? 1 : 0);
        if (we && !e_err) model_store(f3, addr, wd);
    endtask

    initial begin
        logic [31:0] rd;
        bit          seen;
        int          n;

        // reset state
        #12;
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_dmem_we", {31'h0, dmem_we}, 32'h0);
        check("rst_dmem_addr", {20'h0, dmem_addr}, 32'h0);
        check("rst_dmem_din", dmem_din, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 64; i++) preload(i, $urandom);

        // SW then LW of word 4
        run_op("t1_sw", 1'b1, 2, 32'h10, 32'hDEADBEEF, rd);
        check("t1_mem4", mem[4], 32'hDEADBEEF);
        check("t1_wrcount4", wr_count[4], 1);
        run_op("t1_lw", 1'b0, 2, 32'h10, 32'h0, rd);
        check("t1_lw_val", rd, 32'hDEADBEEF);

        // sub-word loads
        preload(4, 32'h8899AABB);
        run_op("t2_lb", 1'b0, 0, 32'h13, 32'h0, rd);
        check("t2_lb_val", rd, 32'hFFFFFF88);
        run_op("t2_lbu", 1'b0, 4, 32'h13, 32'h0, rd);
        check("t2_lbu_val", rd, 32'h00000088);
        run_op("t2_lh", 1'b0, 1, 32'h12, 32'h0, rd);
        check("t2_lh_val", rd, 32'hFFFF8899);

        // read-modify-write stores
        preload(4, 32'h11223344);
        run_op("t3_sb", 1'b1, 0, 32'h11, 32'h000000FF, rd);
        check("t3_sb_mem", mem[4], 32'h1122FF44);
        run_op("t3_sh", 1'b1, 1, 32'h12, 32'h0000ABCD, rd);
        check("t3_sh_mem", mem[4], 32'hABCDFF44);

        // error responses
        run_op("t4_lw_mis", 1'b0, 2, 32'h12, 32'h0, rd);
        run_op("t4_sh_mis", 1'b1, 1, 32'h11, 32'h1234, rd);
        run_op("t4_ill", 1'b0, 3, 32'h10, 32'h0, rd);
        run_op("t4_sw_mis", 1'b1, 2, 32'h13, 32'h5555, rd);
        check("t4_mem4", mem[4], 32'hABCDFF44);

        // reset during the write cycle of an SB
        preload(4, 32'h11223344);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h11; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!dmem_we && n < 5) begin @(posedge clk); #1; n++; end
        check("t5_reached_store", {31'h0, dmem_we}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_we_drop", {31'h0, dmem_we}, 32'h0);
        check("t5_din_zero", dmem_din, 32'h0);
        check("t5_addr_zero", {20'h0, dmem_addr}, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (resp_valid || dmem_we) seen = 1'b1;
        end
        check("t5_no_resp", {31'h0, seen}, 32'h0);
        check("t5_mem4", mem[4], 32'h11223344);
        check("t5_rdata_zero", resp_rdata, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("t5_ready", {31'h0, req_ready}, 32'h1);

        // out-of-range address
        preload(0, 32'h0BAD_F00D);
        run_op("t6_lw_hi", 1'b0, 2, 32'h0001_0000, 32'h0, rd);
`ifdef MEM_LSU_RANGE_CHECK_EN
        check("t6_val", rd, 32'h0);
`else
        check("t6_val", rd, 32'h0BAD_F00D);
`endif

        // random traffic
        for (int i = 0; i < 80; i++) begin
            bit          we;
            int          f3;
            logic [31:0] addr;
            we = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) f3 = $urandom_range(0, 7);
            else if (we)                   f3 = $urandom_range(0, 2);
            else                           f3 = ($urandom_range(0, 4) + 0) ;
            if (!we && f3 == 3) f3 = 4;
            else if (!we && f3 == 4 && $urandom_range(0, 1) == 1) f3 = 5;
            addr = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) addr = addr + (32'($urandom_range(1, 15)) << 14);
            run_op("rand", we, f3, addr, $urandom, rd);
        end

        check("noise_never_written", wr_count[1023], 0);
        for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
